// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter next-address sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HALT
  } pc_state_t;

  typedef enum logic {
    R_BRANCH,
    R_JUMP
  } redir_kind_t;

  localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the PC sequencer and imem.
interface pc_sequencer_if;

  logic imem_req;
  logic imem_ready;
  logic fetch_valid;

  modport master (
    output imem_req,
    output fetch_valid,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  fetch_valid,
    output imem_ready
  );

endinterface

// File: rtl/pc_redirect_buf.sv
// Holds one redirect that arrived while the fetch was stalled.
// A pending jump is never displaced by a later branch; a jump displaces anything.
module pc_redirect_buf
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              capture_branch,
  input  logic              capture_jump,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_target
);

  redir_kind_t pend_kind;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_valid  <= 1'b0;
      pend_kind   <= R_BRANCH;
      pend_target <= '0;
    end else if (clear) begin
      pend_valid <= 1'b0;
    end else if (capture_jump) begin
      pend_valid  <= 1'b1;
      pend_kind   <= R_JUMP;
      pend_target <= jump_target;
    end else if (capture_branch && !(pend_valid && pend_kind == R_JUMP)) begin
      pend_valid  <= 1'b1;
      pend_kind   <= R_BRANCH;
      pend_target <= branch_target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-address controller for the PC register: sequential, branch, jump,
// exception or hold, with a req/ready fetch handshake toward instruction memory.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = 'h80
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     address,
  output logic [ADDR_W-1:0]     next_address,
  input  logic                  stall,
  input  logic                  halt,
  input  logic                  branch_taken,
  input  logic [ADDR_W-1:0]     branch_target,
  input  logic                  jump,
  input  logic [ADDR_W-1:0]     jump_target,
  input  logic                  exception,
  pc_sequencer_if.master        imem,
  output logic                  redirect_pending,
  output logic                  exc_taken,
  output logic                  misaligned
);

  pc_state_t         state, state_next;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_target;
  logic              buf_clear, cap_branch, cap_jump;
  logic              handshake, has_redir;
  logic [ADDR_W-1:0] redir_target, seq_address;

  pc_redirect_buf #(.ADDR_W(ADDR_W)) u_buf (
    .clk            (clk),
    .rst            (rst),
    .clear          (buf_clear),
    .capture_branch (cap_branch),
    .capture_jump   (cap_jump),
    .branch_target  (branch_target),
    .jump_target    (jump_target),
    .pend_valid     (pend_valid),
    .pend_target    (pend_target)
  );

  assign redirect_pending = pend_valid;
  assign handshake        = imem.imem_ready && !stall;
  assign seq_address      = address + ADDR_W'(PC_INCR);
  assign has_redir        = jump || branch_taken || pend_valid;
  assign redir_target     = jump ? jump_target : (branch_taken ? branch_target : pend_target);

  always_ff @(posedge clk) begin
    if (!rst) state <= BOOT;
    else      state <= state_next;
  end

  always_comb begin
    state_next       = state;
    next_address     = address;
    imem.imem_req    = 1'b0;
    imem.fetch_valid = 1'b0;
    exc_taken        = 1'b0;
    misaligned       = 1'b0;
    buf_clear        = 1'b0;
    cap_branch       = 1'b0;
    cap_jump         = 1'b0;
    if (!rst) begin
      next_address = RESET_VECTOR;
    end else begin
      unique case (state)
        BOOT: begin
          next_address = RESET_VECTOR;
          state_next   = FETCH;
        end
        FETCH: begin
          imem.imem_req = 1'b1;
          if (exception) begin
            next_address = EXC_VECTOR;
            exc_taken    = 1'b1;
            buf_clear    = 1'b1;
          end else if (handshake) begin
            imem.fetch_valid = 1'b1;
            buf_clear        = 1'b1;
            // Halt wins over any redirect: the PC steps past the break/syscall.
            if (halt) begin
              state_next   = HALT;
              next_address = seq_address;
            end else if (has_redir) begin
              if (redir_target[1:0] != 2'b00) begin
                next_address = EXC_VECTOR;
                misaligned   = 1'b1;
                exc_taken    = 1'b1;
              end else begin
                next_address = redir_target;
              end
            end else begin
              next_address = seq_address;
            end
          end else begin
            cap_jump   = jump;
            cap_branch = branch_taken;
          end
        end
        HALT: begin
          if (exception) begin
            next_address = EXC_VECTOR;
            exc_taken    = 1'b1;
            buf_clear    = 1'b1;
            state_next   = FETCH;
          end
        end
        default: state_next = BOOT;
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-address controller for the MIPS program counter register.
- Every cycle it computes the address the PC loads: sequential +4, branch, jump or exception vector, or a hold of the current value.
- Sequences instruction-memory fetches with a req/ready handshake and buffers redirects that arrive while a fetch is stalled.
- Sits between the PC register, instruction memory and the decode/execute control logic.

Parameters:
- ADDR_W, 32, address width in bits.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- EXC_VECTOR, 32'h0000_0080, target for exceptions and misaligned redirects.

Ports:
- clk  in  1  clock, rising edge active.
- rst  in  1  reset, synchronous, active-low.
- address  in  ADDR_W  current PC register value.
- next_address  out  ADDR_W  value the PC loads on the next rising edge; combinational.
- stall  in  1  pipeline stall from downstream.
- halt  in  1  halt request (break/syscall); sampled only in FETCH.
- branch_taken  in  1  branch redirect request.
- branch_target  in  ADDR_W  branch destination.
- jump  in  1  jump redirect request.
- jump_target  in  ADDR_W  jump destination.
- exception  in  1  exception request.
- imem_req  out  1  fetch request at address.
- imem_ready  in  1  instruction memory accepts/returns this cycle.
- fetch_valid  out  1  pulse: fetch at address completed and accepted.
- redirect_pending  out  1  a buffered redirect is waiting.
- exc_taken  out  1  pulse: the PC is being forced to EXC_VECTOR this cycle.
- misaligned  out  1  pulse: the selected redirect target had [1:0] != 0.

Behaviour:
- States are BOOT, FETCH and HALT. Registered state is the FSM state plus pend_valid and pend_target.
- Reset (rst==0 at a rising edge):
  - state goes to BOOT and pend_valid to 0.
  - While rst==0: next_address=RESET_VECTOR, imem_req=0, fetch_valid=0, exc_taken=0, misaligned=0.
- BOOT (one cycle):
  - next_address=RESET_VECTOR, imem_req=0.
  - Next state is FETCH.
- FETCH:
  - imem_req=1.
  - Redirect source selection by priority: exception > jump > branch > pend.
  - exception=1:
    - Overrides stall, ready and halt.
    - next_address=EXC_VECTOR, exc_taken=1, fetch_valid=0.
    - pend_valid cleared; stay in FETCH.
  - Handshake (imem_ready=1 and stall=0):
    - fetch_valid=1.
    - next_address = selected redirect target if any, else address+4.
    - pend_valid cleared.
    - If halt=1: next state is HALT and next_address=address+4.
  - No handshake (ready=0 or stall=1):
    - next_address=address (hold).
    - An incoming jump/branch is written to pend_target and pend_valid is set.
    - An incoming jump overwrites a pending branch; an incoming branch does not overwrite a pending jump (a pend_kind bit is stored).
    - A branch replaces a pending branch.
  - Misaligned target:
    - If the applied redirect target has bits [1:0] != 0: next_address=EXC_VECTOR, misaligned=1, exc_taken=1.
    - The check is made when the target is applied, not when it is buffered.
- HALT:
  - imem_req=0 and next_address=address.
  - Leave on exception only (to FETCH via the exception rule); otherwise wait for reset.
  - branch/jump inputs are ignored.
- Arithmetic: address+4 is modulo 2^ADDR_W, so 32'hFFFF_FFFC wraps to 32'h0.
- Zero-latency path: next_address depends combinationally on the inputs and the state. There is no registered output latency; the PC update occurs on the next edge.
- redirect_pending equals pend_valid.
- Reset mid-operation: a pending redirect and HALT are both discarded, and the sequence restarts with BOOT.

Decomposition:
- Package pc_seq_pkg holds:
  - the pc_state_t enum {BOOT, FETCH, HALT};
  - the redir_kind_t enum {R_BRANCH, R_JUMP};
  - the localparam PC_INCR=4.
- One sub-module, pc_redirect_buf: holds pend_valid/pend_kind/pend_target and implements the capture/overwrite/clear rules.
- FSM and next-address mux stay in pc_sequencer.

Test Plan:
- Reset and sequential fetch: rst=0 for 2 cycles, then 1; imem_ready=1; PC fed back. Required: next_address 0x0 (BOOT), then 0x4, 0x8, 0xC; fetch_valid high from the first FETCH cycle.
- Memory wait: address=0x10, imem_ready=0 for 3 cycles, branch_taken=1 with target 0x40 in cycle 1. Required: next_address holds 0x10 and redirect_pending=1 for 3 cycles; on ready, next_address=0x40 and redirect_pending=0.
- Priority: branch_taken (0x40) and jump (0x80) in the same cycle with stall=1, then stall=0. Required: jump target 0x80 is applied; a later branch while stalled does not replace the pending jump.
- Exception during stall: stall=1 with a pending branch, exception=1. Required: same-cycle next_address=0x80, exc_taken=1, pending cleared.
- Misaligned and wrap: jump_target=0x102 gives next_address=0x80 with misaligned=1. address=0xFFFF_FFFC with ready=1 gives next_address=0x0.
- Halt: halt=1 with handshake at 0x20 gives next_address 0x24, then held at 0x24 with imem_req=0; a branch is ignored; exception=1 gives 0x80 and a return to FETCH.
